// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs, FSM states, ALU codes.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 5;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR  = 6'h27;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_IEXEC   = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  // How the decoder picks the ALU operation for the current state.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_IMM   = 2'd3
  } alu_op_t;

  typedef struct packed {
    logic [ALU_W-1:0] sel;
    logic             c_in;
  } alu_code_t;

  localparam alu_code_t ALU_NONE = '{sel: 5'b00000, c_in: 1'b0};
  localparam alu_code_t ALU_ADD  = '{sel: 5'b00001, c_in: 1'b0};
  localparam alu_code_t ALU_SUB  = '{sel: 5'b00010, c_in: 1'b1};
  localparam alu_code_t ALU_AND  = '{sel: 5'b00100, c_in: 1'b0};
  localparam alu_code_t ALU_OR   = '{sel: 5'b00101, c_in: 1'b0};
  localparam alu_code_t ALU_XOR  = '{sel: 5'b00110, c_in: 1'b0};
  localparam alu_code_t ALU_NOR  = '{sel: 5'b00101, c_in: 1'b1};

endpackage

// File: rtl/alu_decoder.sv
// Maps (alu_op, funct, opcode) to the shared ALU select/carry-in; flags unsupported R-type functs.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_t          i_alu_op,
  input  logic [OP_W-1:0]  i_funct,
  input  logic [OP_W-1:0]  i_opcode,
  output logic [ALU_W-1:0] o_alu_select,
  output logic             o_alu_c_in,
  output logic             o_funct_ok
);

  alu_code_t w_code;

  always_comb begin
    w_code     = ALU_ADD;
    o_funct_ok = 1'b1;
    case (i_alu_op)
      ALUOP_ADD: w_code = ALU_ADD;
      ALUOP_SUB: w_code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD, FN_ADDU: w_code = ALU_ADD;
          FN_SUB, FN_SUBU: w_code = ALU_SUB;
          FN_AND:          w_code = ALU_AND;
          FN_OR:           w_code = ALU_OR;
          FN_XOR:          w_code = ALU_XOR;
          FN_NOR:          w_code = ALU_NOR;
          default: begin
            w_code     = ALU_NONE;
            o_funct_ok = 1'b0;
          end
        endcase
      end
      // Immediate extension is the datapath's job; only the operation is chosen here.
      ALUOP_IMM: begin
        case (i_opcode)
          OP_ANDI: w_code = ALU_AND;
          OP_ORI:  w_code = ALU_OR;
          default: w_code = ALU_ADD;
        endcase
      end
      default: w_code = ALU_ADD;
    endcase
  end

  assign o_alu_select = w_code.sel;
  assign o_alu_c_in   = w_code.c_in;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath (Moore decode, memory-ready/zero qualified enables).
// Build option: ILLEGAL_TRAP_EN makes the ILLEGAL state terminal and raises a sticky illegal_instr.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned PC_INC = 4
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALU_W-1:0]   alu_select,
  output logic               alu_c_in,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_o
);

  // The PC step lives on the datapath's ALU b-input mux; a zero step is a wiring error.
  if (PC_INC == 0) begin : g_pc_inc_chk
    $error("multicycle_ctrl: PC_INC must be nonzero");
  end

  state_t           r_state;
  state_t           w_next;
  alu_op_t          w_alu_op;
  logic             w_alu_use;
  logic [ALU_W-1:0] w_dec_sel;
  logic             w_dec_cin;
  logic             w_funct_ok;

  alu_decoder u_alu_decoder (
    .i_alu_op    (w_alu_op),
    .i_funct     (funct),
    .i_opcode    (opcode),
    .o_alu_select(w_dec_sel),
    .o_alu_c_in  (w_dec_cin),
    .o_funct_ok  (w_funct_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:               w_next = S_MEMADR;
          OP_RTYPE:                   w_next = S_EXEC;
          OP_BEQ:                     w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   w_next = S_IEXEC;
          OP_J:                       w_next = S_JUMP;
          default:                    w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = w_funct_ok ? S_ALUWB : S_ILLEGAL;
      S_IEXEC:  w_next = S_IWB;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL: w_next = S_ILLEGAL;
`else
      S_ILLEGAL: w_next = S_FETCH;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // Reset suppresses every enable and zeroes the muxes in the same cycle.
  always_comb begin
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    w_alu_op   = ALUOP_ADD;
    w_alu_use  = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          w_alu_use = 1'b1;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          w_alu_use = 1'b1;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          w_alu_use = 1'b1;
        end
        S_MEMRD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          w_alu_op  = ALUOP_FUNCT;
          w_alu_use = 1'b1;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          w_alu_op  = ALUOP_IMM;
          w_alu_use = 1'b1;
        end
        S_IWB:    reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_src    = 2'b01;
          pc_en     = zero;
          w_alu_op  = ALUOP_SUB;
          w_alu_use = 1'b1;
        end
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_select = w_alu_use ? w_dec_sel : '0;
  assign alu_c_in   = w_alu_use & w_dec_cin;
  assign state_o    = STATE_W'(r_state);

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (reset)                    r_illegal <= 1'b0;
    else if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
  end

  assign illegal_instr = r_illegal;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; honours ILLEGAL_TRAP_EN when defined.
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       i_or_d, mem_read, mem_write, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a, alu_c_in, reg_dst, mem_to_reg, reg_write, illegal_instr;
  logic [4:0] alu_select;
  logic [3:0] state_o;
  logic [4:0] en;

  int n_chk = 0;
  int n_err = 0;

  multicycle_ctrl #(.PC_INC(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_select(alu_select), .alu_c_in(alu_c_in),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  assign en = {mem_read, mem_write, ir_write, pc_en, reg_write};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let the combinational outputs settle.
  task automatic next_cyc(input logic r, input logic rdy, input logic z);
    @(negedge clk);
    reset = r; mem_ready = rdy; zero = z;
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn;
    next_cyc(1'b0, 1'b1, 1'b0);
    check("fetch_state", 32'(state_o), 32'd0);
    check("fetch_ir_pc", 32'({ir_write, pc_en}), 32'b11);
    next_cyc(1'b0, 1'b1, 1'b0);
    check("decode_state", 32'(state_o), 32'd1);
  endtask

  initial begin
    int  cycles, fw, rw, n_ir, n_rd, n_wb, n_mw, bad;
    logic wb_m2r, wb_dst, done, rdy;

    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h00; funct = 6'h27;

    // Reset held two cycles
    next_cyc(1'b1, 1'b1, 1'b0);
    check("rst0_en", 32'(en), 32'd0);
    check("rst0_alu", 32'({alu_select, alu_c_in, alu_src_b, pc_src}), 32'd0);
    next_cyc(1'b1, 1'b1, 1'b0);
    check("rst1_state", 32'(state_o), 32'd0);
    check("rst1_en", 32'(en), 32'd0);

    // R-type NOR
    fetch_decode(6'h00, 6'h27);
    check("decode_srcb", 32'(alu_src_b), 32'd3);
    check("decode_add", 32'({alu_select, alu_c_in}), 32'b00001_0);
    next_cyc(1'b0, 1'b1, 1'b0);
    check("exec_state", 32'(state_o), 32'd6);
    check("exec_nor", 32'({alu_select, alu_c_in}), 32'b00101_1);
    check("exec_srcs", 32'({alu_src_a, alu_src_b}), 32'b1_00);
    next_cyc(1'b0, 1'b1, 1'b0);
    check("aluwb_ctl", 32'({reg_write, reg_dst, mem_to_reg}), 32'b110);

    // lw with 3 FETCH waits and 3 MEMRD waits
    opcode = 6'h23;
    cycles = 0; fw = 0; rw = 0; n_ir = 0; n_rd = 0; n_wb = 0;
    wb_m2r = 1'b0; wb_dst = 1'b1; done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      rdy = 1'b1;
      if (state_o == 4'd0 && fw < 3) begin rdy = 1'b0; fw++; end
      if (state_o == 4'd3 && rw < 3) begin rdy = 1'b0; rw++; end
      reset = 1'b0; mem_ready = rdy; zero = 1'b0;
      #1;
      cycles++;
      if (ir_write) n_ir++;
      if (mem_read && i_or_d) n_rd++;
      if (reg_write) begin n_wb++; wb_m2r = mem_to_reg; wb_dst = reg_dst; end
      if (state_o == 4'd4) begin done = 1'b1; break; end
    end
    check("lw_reached_wb", 32'(done), 32'd1);
    check("lw_cycles", 32'(cycles), 32'd11);
    check("lw_ir_writes", 32'(n_ir), 32'd1);
    check("lw_memrd_cycles", 32'(n_rd), 32'd4);
    check("lw_reg_writes", 32'(n_wb), 32'd1);
    check("lw_wb_sel", 32'({wb_m2r, wb_dst}), 32'b10);

    // beq taken then not taken
    fetch_decode(6'h04, 6'h00);
    next_cyc(1'b0, 1'b1, 1'b1);
    check("beq_t_state", 32'(state_o), 32'd10);
    check("beq_t_pc", 32'({pc_en, pc_src}), 32'b1_01);
    check("beq_sub", 32'({alu_select, alu_c_in}), 32'b00010_1);
    fetch_decode(6'h04, 6'h00);
    next_cyc(1'b0, 1'b1, 1'b0);
    check("beq_nt_pc", 32'({pc_en, pc_src}), 32'b0_01);

    // sw with 2 wait cycles
    fetch_decode(6'h2B, 6'h00);
    next_cyc(1'b0, 1'b1, 1'b0);
    check("memadr_ctl", 32'({alu_src_a, alu_src_b, alu_select}), 32'b1_10_00001);
    n_mw = 0; bad = 0;
    for (int k = 0; k < 3; k++) begin
      next_cyc(1'b0, (k == 2), 1'b0);
      if (mem_write) n_mw++;
      if (!i_or_d) bad++;
    end
    next_cyc(1'b0, 1'b0, 1'b0);
    if (mem_write) n_mw++;
    check("sw_write_cycles", 32'(n_mw), 32'd3);
    check("sw_iord", 32'(bad), 32'd0);
    check("sw_back_fetch", 32'(state_o), 32'd0);

    // sw abandoned by reset on its 2nd MEMWR cycle
    fetch_decode(6'h2B, 6'h00);
    next_cyc(1'b0, 1'b1, 1'b0);
    next_cyc(1'b0, 1'b0, 1'b0);
    check("swr_write1", 32'({mem_write, i_or_d}), 32'b11);
    next_cyc(1'b1, 1'b0, 1'b0);
    check("swr_rst_en", 32'({en, i_or_d}), 32'd0);
    next_cyc(1'b0, 1'b0, 1'b0);
    check("swr_state", 32'(state_o), 32'd0);
    check("swr_no_write", 32'(mem_write), 32'd0);

    // jump, then ori
    fetch_decode(6'h02, 6'h00);
    next_cyc(1'b0, 1'b1, 1'b0);
    check("jump_pc", 32'({pc_en, pc_src}), 32'b1_10);
    fetch_decode(6'h0D, 6'h00);
    next_cyc(1'b0, 1'b1, 1'b0);
    check("iexec_or", 32'({alu_src_a, alu_src_b, alu_select, alu_c_in}), 32'b1_10_00101_0);
    next_cyc(1'b0, 1'b1, 1'b0);
    check("iwb_ctl", 32'({state_o, reg_write, reg_dst, mem_to_reg}), 32'b1001_100);

`ifdef ILLEGAL_TRAP_EN
    fetch_decode(6'h3F, 6'h00);
    n_ir = 0; bad = 0;
    for (int k = 0; k < 10; k++) begin
      next_cyc(1'b0, 1'b1, 1'b0);
      if (ir_write) n_ir++;
      if (!illegal_instr || state_o != 4'd12 || en != 5'd0) bad++;
    end
    check("trap_no_ir", 32'(n_ir), 32'd0);
    check("trap_held", 32'(bad), 32'd0);
`else
    fetch_decode(6'h00, 6'h3F);
    next_cyc(1'b0, 1'b1, 1'b0);
    check("badfn_exec", 32'(state_o), 32'd6);
    next_cyc(1'b0, 1'b0, 1'b0);
    check("badfn_illegal", 32'({state_o, en}), 32'({4'd12, 5'd0}));
    next_cyc(1'b0, 1'b0, 1'b0);
    check("badfn_fetch", 32'(state_o), 32'd0);
    fetch_decode(6'h3F, 6'h00);
    next_cyc(1'b0, 1'b0, 1'b0);
    check("illop_nop", 32'({state_o, en, illegal_instr}), 32'({4'd12, 5'd0, 1'b0}));
    next_cyc(1'b0, 1'b0, 1'b0);
    check("illop_fetch", 32'({state_o, illegal_instr}), 32'({4'd0, 1'b0}));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
